// File: rtl/lut_init_engine_if.sv
// Host/control bundle for lut_init_engine.
// LUT_PARITY_EN adds wr_bad_par / rd_perr.
interface lut_init_engine_if #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic              start;
  logic [1:0]        init_mode;
  logic [DATA_W-1:0] fill_value;
  logic [DATA_W-1:0] step;
  logic              busy;
  logic              done;
  logic              table_valid;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef LUT_PARITY_EN
  logic              wr_bad_par;
  logic              rd_perr;
`endif

  modport master (
`ifdef LUT_PARITY_EN
    output wr_bad_par,
    input  rd_perr,
`endif
    output start, init_mode, fill_value, step,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  busy, done, table_valid, rd_data, rd_valid
  );

  modport slave (
`ifdef LUT_PARITY_EN
    input  wr_bad_par,
    output rd_perr,
`endif
    input  start, init_mode, fill_value, step,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output busy, done, table_valid, rd_data, rd_valid
  );
endinterface

// File: rtl/lut_init_engine.sv
// Lookup-table store with a sequential pattern loader.
// Optional even parity per entry: define LUT_PARITY_EN.
module lut_init_engine #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clock,
  input logic resetN,
  lut_init_engine_if.slave bus
);

`ifdef LUT_PARITY_EN
  localparam int EW = DATA_W + 1;
`else
  localparam int EW = DATA_W;
`endif
  localparam int IW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] acc_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
`ifdef LUT_PARITY_EN
  logic              perr_q;
`endif

  logic [EW-1:0]     mem_q [DEPTH];

  logic [IW-1:0]     idx_ext;
  logic [DATA_W-1:0] load_val;
  logic              wr_in;
  logic              rd_in;
  logic              load_we;
  logic              host_we;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_val;
  logic [EW-1:0]     wr_word;
  logic [EW-1:0]     rd_word;

  // Pattern value for the entry being loaded and write-port muxing.
  always_comb begin
    idx_ext  = IW'(idx_q);
    load_val = '0;
    unique case (mode_q)
      2'd0: load_val = idx_ext[DATA_W-1:0];
      2'd1: load_val = fill_q;
      2'd2: load_val = acc_q;
      2'd3: load_val = ~idx_ext[DATA_W-1:0];
    endcase
    wr_in   = {1'b0, bus.wr_addr} < DEPTH_X;
    rd_in   = {1'b0, bus.rd_addr} < DEPTH_X;
    load_we = (state_q == S_LOAD);
    host_we = (state_q == S_IDLE) && bus.wr_en
              && !bus.start && wr_in;
    wr_idx  = load_we ? idx_q : bus.wr_addr;
    wr_val  = load_we ? load_val : bus.wr_data;
`ifdef LUT_PARITY_EN
    wr_word = {(^wr_val) ^ (host_we & bus.wr_bad_par),
               wr_val};
`else
    wr_word = wr_val;
`endif
    rd_word = rd_in ? mem_q[bus.rd_addr] : '0;
  end

  // Table storage; never cleared by reset.
  always_ff @(posedge clock) begin
    if (load_we || host_we)
      mem_q[wr_idx] <= wr_word;
  end

  // Load FSM plus registered read port.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mode_q     <= '0;
      fill_q     <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef LUT_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_word[DATA_W-1:0];
`ifdef LUT_PARITY_EN
            perr_q     <= ^rd_word;
`endif
          end
          if (bus.start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            mode_q  <= bus.init_mode;
            fill_q  <= bus.fill_value;
            step_q  <= bus.step;
            acc_q   <= bus.fill_value;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          idx_q <= idx_q + 1'b1;
          acc_q <= acc_q + step_q;
          if (idx_q == LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_valid = valid_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
`ifdef LUT_PARITY_EN
  assign bus.rd_perr     = perr_q;
`endif

endmodule

// File: tb/tb_lut_init_engine.sv
// Bench for lut_init_engine (DATA_W=8, DEPTH=256).
// Reference table is rebuilt from pattern formulas.
module tb_lut_init_engine;
  localparam int DW = 8;
  localparam int DP = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_init_engine_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  lut_init_engine #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock (clk),
    .resetN(rst_n),
    .bus   (bus)
  );

  int ncmp = 0;
  int nfail = 0;
  logic [DW-1:0] model [DP];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(int m,
      logic [DW-1:0] f, logic [DW-1:0] s, int i);
    case (m)
      0: return DW'(i);
      1: return f;
      2: return DW'(int'(f) + i * int'(s));
      default: return ~DW'(i);
    endcase
  endfunction

  task automatic quiet();
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
`ifdef LUT_PARITY_EN
    bus.wr_bad_par = 1'b0;
`endif
  endtask

  task automatic rd(int a, logic [DW-1:0] exp, string tag);
    bus.rd_en = 1'b1;
    bus.rd_addr = DW'(a);
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_vld"}, bus.rd_valid, 1);
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic wr(int a, logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = DW'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    model[a] = d;
  endtask

  // poke: cycle at which start/rd/wr are pulsed mid-load
  task automatic run_load(int m, logic [DW-1:0] f,
                          logic [DW-1:0] s, int poke);
    int bcnt;
    int dcnt;
    bcnt = 0;
    dcnt = 0;
    bus.init_mode = 2'(m);
    bus.fill_value = f;
    bus.step = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
    chk("tv_clear", bus.table_valid, 0);
    for (int c = 0; c < DP + 6; c++) begin
      if (bus.busy) bcnt++;
      if (bus.done) dcnt++;
      if (c == poke + 1 && poke >= 0)
        chk("rd_rejected", bus.rd_valid, 0);
      bus.start = (c == poke);
      bus.rd_en = (c == poke);
      bus.wr_en = (c == poke);
      bus.wr_addr = 8'd5;
      bus.wr_data = 8'hEE;
      bus.init_mode = (c == poke) ? ~2'(m) : 2'(m);
      bus.fill_value = (c == poke) ? ~f : f;
      tick();
    end
    quiet();
    chk("busy_cycles", bcnt, DP);
    chk("done_pulses", dcnt, 1);
    chk("tv_set", bus.table_valid, 1);
    chk("busy_fall", bus.busy, 0);
    for (int i = 0; i < DP; i++) model[i] = pat(m, f, s, i);
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < DP; i++) rd(i, model[i], tag);
  endtask

  initial begin
    int m;
    logic [DW-1:0] f, s, d, old;
    int a, b, dw, dr;
    quiet();
    bus.init_mode = '0;
    bus.fill_value = '0;
    bus.step = '0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tv", bus.table_valid, 0);
    chk("rst_rdv", bus.rd_valid, 0);
    chk("rst_rdd", bus.rd_data, 0);
    #10 rst_n = 1'b1;
    tick();

    // identity load, read 128
    run_load(0, 8'h00, 8'h00, -1);
    rd(128, 8'd128, "t1_rd128");
    tick();
    chk("t1_rdv_drop", bus.rd_valid, 0);
    chk("t1_rdd_hold", bus.rd_data, 128);

    // ramp 10 + 3i
    run_load(2, 8'd10, 8'd3, -1);
    rd(100, 8'd54, "t2_rd100");
    rd(0, 8'd10, "t2_rd0");
    rd(255, model[255], "t2_rd255");
    sweep("t2_sweep");

    // constant with a mid-load restart/read/write attempt
    run_load(1, 8'hA5, 8'h00, 40);
    sweep("t3_sweep");

    // reset during load at entry 50
    bus.init_mode = 2'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_tv", bus.table_valid, 0);
    chk("t4_rdd", bus.rd_data, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) model[i] = pat(3, 0, 0, i);
    tick();
    chk("t4_tv_after", bus.table_valid, 0);
    rd(49, model[49], "t4_rd49");
    rd(50, model[50], "t4_rd50");
    run_load(3, 8'h00, 8'h00, -1);
    rd(50, model[50], "t4_rd50_new");

    // same-address read/write
    old = model[7];
    bus.wr_en = 1'b1;
    bus.wr_addr = 8'd7;
    bus.wr_data = 8'h3C;
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'd7;
    tick();
    quiet();
    chk("t5_old", bus.rd_data, old);
    model[7] = 8'h3C;
    rd(7, 8'h3C, "t5_new");
    chk("t5_tv_kept", bus.table_valid, 1);

    // random load and random host traffic
    m = $urandom_range(0, 3);
    f = DW'($urandom);
    s = DW'($urandom);
    run_load(m, f, s, int'($urandom_range(0, DP - 1)));
    sweep("rnd_load");
    for (int k = 0; k < 400; k++) begin
      a = $urandom_range(0, DP - 1);
      b = (k % 5 == 0) ? a : $urandom_range(0, DP - 1);
      d = DW'($urandom);
      dw = $urandom_range(0, 1);
      dr = $urandom_range(0, 1);
      old = model[b];
      bus.wr_en = dw[0];
      bus.wr_addr = DW'(a);
      bus.wr_data = d;
      bus.rd_en = dr[0];
      bus.rd_addr = DW'(b);
      tick();
      quiet();
      chk("rnd_rdv", bus.rd_valid, dr);
      if (dr != 0) chk("rnd_rdd", bus.rd_data, old);
      if (dw != 0) model[a] = d;
    end
    sweep("rnd_final");

`ifdef LUT_PARITY_EN
    bus.wr_bad_par = 1'b1;
    wr(3, 8'h5A);
    bus.wr_bad_par = 1'b0;
    rd(3, 8'h5A, "par_bad_data");
    chk("par_bad", bus.rd_perr, 1);
    wr(4, 8'h5B);
    rd(4, 8'h5B, "par_ok_data");
    chk("par_ok", bus.rd_perr, 0);
    rd(9, model[9], "par_load_data");
    chk("par_load", bus.rd_perr, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
